// File: rtl/mem_port_arbiter.sv
// Serializes single-beat fetch and data transactions onto one memory port, alternating on contention.
// mem_valid follows the grant edge; completion pulses one cycle after mem_ready or a TIMEOUT-cycle abort; other requests wait.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ready,
  output logic [DW-1:0] i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          mem_valid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_IBUSY = 2'd1;
  localparam logic [1:0] S_DBUSY = 2'd2;

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic          last_d_q, last_d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_valid_q, mem_valid_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          i_ready_q, i_ready_d, i_err_q, i_err_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic          d_ready_q, d_ready_d, d_err_q, d_err_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  // A port whose completion pulse is showing this cycle has not retired its request yet.
  logic i_elig, d_elig;
  assign i_elig = i_req && !i_ready_q;
  assign d_elig = d_req && !d_ready_q;

  always_comb begin
    logic grant_i, grant_d, done;
    logic [DW-1:0] rdata;
    state_d     = state_q;
    last_d_d    = last_d_q;
    cnt_d       = cnt_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ready_d   = 1'b0;
    i_err_d     = 1'b0;
    i_rdata_d   = '0;
    d_ready_d   = 1'b0;
    d_err_d     = 1'b0;
    d_rdata_d   = '0;
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    done        = 1'b0;
    rdata       = '0;
    case (state_q)
      S_IDLE: begin
        if (i_elig && d_elig) begin
          grant_d = !last_d_q;
          grant_i = last_d_q;
        end else begin
          grant_i = i_elig;
          grant_d = d_elig;
        end
        if (grant_d) begin
          state_d     = S_DBUSY;
          last_d_d    = 1'b1;
          cnt_d       = '0;
          mem_valid_d = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else if (grant_i) begin
          state_d     = S_IBUSY;
          last_d_d    = 1'b0;
          cnt_d       = '0;
          mem_valid_d = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
        end
      end
      S_IBUSY, S_DBUSY: begin
        done = mem_ready || (cnt_q == CNT_LAST);
        // Timed-out transactions and writes return zero data.
        rdata = (mem_ready && !mem_we_q) ? mem_rdata : '0;
        if (done) begin
          state_d     = S_IDLE;
          mem_valid_d = 1'b0;
          if (state_q == S_IBUSY) begin
            i_ready_d = 1'b1;
            i_err_d   = !mem_ready;
            i_rdata_d = rdata;
          end else begin
            d_ready_d = 1'b1;
            d_err_d   = !mem_ready;
            d_rdata_d = rdata;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      last_d_q    <= 1'b0;
      cnt_q       <= '0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ready_q   <= 1'b0;
      i_err_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_ready_q   <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      cnt_q       <= cnt_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ready_q   <= i_ready_d;
      i_err_q     <= i_err_d;
      i_rdata_q   <= i_rdata_d;
      d_ready_q   <= d_ready_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ready   = i_ready_q;
  assign i_err     = i_err_q;
  assign i_rdata   = i_rdata_q;
  assign d_ready   = d_ready_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios followed by randomized traffic against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 16;

  logic          clk, reset;
  logic          i_req, i_ready, i_err;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_ready, d_err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_valid, mem_we, mem_ready, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  int   grants, pend, vcount;
  logic exp_d;

  // Reference model state for the random phase
  bit   ip, dp, m_last_d;
  txn_t it, dt, ot;
  int   owner, age, waitc, pulse, cur_pulse, r;
  logic [31:0] prdata;
  logic perr;

  initial begin
    reset = 1'b0;
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_i_ready", 32'(i_ready), 32'd0);
    chk("rst_d_ready", 32'(d_ready), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    reset = 1'b1;

    // Single read, zero wait
    i_req = 1; i_addr = 32'h40;
    chk("rd0_valid_c0", 32'(mem_valid), 32'd0);
    step();
    chk("rd0_valid_c1", 32'(mem_valid), 32'd1);
    chk("rd0_addr", mem_addr, 32'h40);
    chk("rd0_we", 32'(mem_we), 32'd0);
    chk("rd0_i_ready_c1", 32'(i_ready), 32'd0);
    mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    step();
    chk("rd0_i_ready_c2", 32'(i_ready), 32'd1);
    chk("rd0_i_rdata", i_rdata, 32'hDEADBEEF);
    chk("rd0_i_err", 32'(i_err), 32'd0);
    chk("rd0_valid_c2", 32'(mem_valid), 32'd0);
    i_req = 0; mem_ready = 0; mem_rdata = '0;
    step();
    chk("rd0_i_ready_c3", 32'(i_ready), 32'd0);
    chk("rd0_i_rdata_c3", i_rdata, 32'd0);

    // Contention: D, I, D, I
    i_req = 1; i_addr = 32'h200;
    d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'h1234;
    grants = 0; pend = 0;
    for (int c = 0; c < 40 && (grants < 4 || pend != 0); c++) begin
      if (pend == 2) begin
        chk("cont_d_ready", 32'(d_ready), 32'd1);
        chk("cont_d_rdata", d_rdata, 32'd0);
      end
      if (pend == 1) begin
        chk("cont_i_ready", 32'(i_ready), 32'd1);
        chk("cont_i_rdata", i_rdata, 32'h77);
      end
      pend = 0;
      if (grants == 4) begin
        i_req = 0; d_req = 0;
      end
      mem_ready = 0;
      if (mem_valid === 1'b1) begin
        exp_d = (grants % 2 == 0);
        chk("cont_we", 32'(mem_we), 32'(exp_d));
        chk("cont_addr", mem_addr, exp_d ? 32'h80 : 32'h200);
        chk("cont_wdata", mem_wdata, exp_d ? 32'h1234 : 32'h0);
        mem_ready = 1; mem_rdata = 32'h77;
        pend = exp_d ? 2 : 1;
        grants++;
      end
      step();
    end
    chk("cont_grants", 32'(grants), 32'd4);
    mem_ready = 0;

    // Wait states: ready on the fourth valid cycle
    d_req = 1; d_we = 0; d_addr = 32'h300; d_wdata = 32'h0;
    step();
    for (int k = 0; k < 4; k++) begin
      chk("ws_valid", 32'(mem_valid), 32'd1);
      chk("ws_addr", mem_addr, 32'h300);
      chk("ws_we", 32'(mem_we), 32'd0);
      chk("ws_d_ready_early", 32'(d_ready), 32'd0);
      mem_ready = (k == 3);
      mem_rdata = (k == 3) ? 32'h55 : 32'hBAD;
      step();
    end
    chk("ws_d_ready", 32'(d_ready), 32'd1);
    chk("ws_d_rdata", d_rdata, 32'h55);
    chk("ws_d_err", 32'(d_err), 32'd0);
    d_req = 0; mem_ready = 0;
    step();

    // Timeout with memory silent
    d_req = 1; d_we = 0; d_addr = 32'h400; mem_rdata = 32'hFFFFFFFF;
    step();
    vcount = 0;
    while (mem_valid === 1'b1 && vcount < 40) begin
      vcount++;
      step();
    end
    chk("to_valid_cycles", 32'(vcount), 32'(TIMEOUT));
    chk("to_d_ready", 32'(d_ready), 32'd1);
    chk("to_d_err", 32'(d_err), 32'd1);
    chk("to_d_rdata", d_rdata, 32'd0);
    d_req = 0;
    step();
    chk("to_d_ready_clear", 32'(d_ready), 32'd0);
    chk("to_d_err_clear", 32'(d_err), 32'd0);

    // Ready on the last allowed cycle is a normal completion
    d_req = 1; d_addr = 32'h404; mem_rdata = 32'hABCD;
    step();
    for (int k = 0; k < TIMEOUT; k++) begin
      chk("tol_valid", 32'(mem_valid), 32'd1);
      mem_ready = (k == TIMEOUT - 1);
      step();
    end
    chk("tol_d_ready", 32'(d_ready), 32'd1);
    chk("tol_d_err", 32'(d_err), 32'd0);
    chk("tol_d_rdata", d_rdata, 32'hABCD);
    d_req = 0; mem_ready = 0;
    step();

    // Held instruction request: no regrant during its own pulse
    i_req = 1; i_addr = 32'h500;
    for (int c = 0; c < 12; c++) begin
      chk("ndg_valid", 32'(mem_valid), 32'(c % 3 == 1));
      chk("ndg_i_ready", 32'(i_ready), 32'(c % 3 == 2));
      if (c == 11) i_req = 0;
      mem_ready = mem_valid;
      mem_rdata = 32'(c);
      step();
    end
    mem_ready = 0;

    // Asynchronous reset mid-DBUSY
    d_req = 1; d_we = 1; d_addr = 32'h600; d_wdata = 32'h99;
    step();
    step();
    chk("ar_valid_before", 32'(mem_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_mem_valid", 32'(mem_valid), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_mem_addr", mem_addr, 32'd0);
    chk("ar_mem_we", 32'(mem_we), 32'd0);
    chk("ar_mem_wdata", mem_wdata, 32'd0);
    d_req = 0;
    step();
    reset = 1'b1;
    i_req = 1; i_addr = 32'h100;
    chk("ar_rel_valid_c0", 32'(mem_valid), 32'd0);
    chk("ar_rel_d_ready_c0", 32'(d_ready), 32'd0);
    step();
    chk("ar_rel_valid_c1", 32'(mem_valid), 32'd1);
    chk("ar_rel_addr", mem_addr, 32'h100);
    chk("ar_rel_d_ready_c1", 32'(d_ready), 32'd0);
    mem_ready = 1; mem_rdata = 32'h11;
    step();
    chk("ar_rel_i_ready", 32'(i_ready), 32'd1);
    chk("ar_rel_d_ready_c2", 32'(d_ready), 32'd0);
    i_req = 0; mem_ready = 0;
    step();

    // Randomized traffic; instruction port was granted last
    ip = 0; dp = 0; m_last_d = 0; owner = 0; pulse = 0; age = 0; waitc = 0;
    prdata = '0; perr = 0;
    it = '{we: 1'b0, addr: 32'h0, wdata: 32'h0};
    dt = it; ot = it;
    for (int c = 0; c < 3000; c++) begin
      cur_pulse = pulse;
      chk("r_i_ready", 32'(i_ready), 32'(cur_pulse == 1));
      chk("r_d_ready", 32'(d_ready), 32'(cur_pulse == 2));
      chk("r_i_rdata", i_rdata, (cur_pulse == 1) ? prdata : 32'h0);
      chk("r_d_rdata", d_rdata, (cur_pulse == 2) ? prdata : 32'h0);
      chk("r_i_err", 32'(i_err), 32'((cur_pulse == 1) && perr));
      chk("r_d_err", 32'(d_err), 32'((cur_pulse == 2) && perr));
      chk("r_busy", 32'(busy), 32'(owner != 0));
      chk("r_mem_valid", 32'(mem_valid), 32'(owner != 0));
      if (owner != 0) begin
        chk("r_mem_addr", mem_addr, ot.addr);
        chk("r_mem_we", 32'(mem_we), 32'(ot.we));
        chk("r_mem_wdata", mem_wdata, ot.wdata);
      end
      if (cur_pulse == 1) ip = 0;
      if (cur_pulse == 2) dp = 0;
      if (!ip && $urandom_range(99) < 40) begin
        ip = 1;
        it.addr = $urandom & 32'hFFFF_FFFC;
        it.we = 1'b0;
        it.wdata = 32'h0;
      end
      if (!dp && $urandom_range(99) < 40) begin
        dp = 1;
        dt.addr = $urandom & 32'hFFFF_FFFC;
        dt.we = 1'($urandom);
        dt.wdata = $urandom;
      end
      i_req = ip; i_addr = it.addr;
      d_req = dp; d_we = dt.we; d_addr = dt.addr; d_wdata = dt.wdata;
      mem_rdata = $urandom;
      mem_ready = (owner != 0) && (age == waitc);
      pulse = 0;
      if (owner != 0) begin
        if (mem_ready || age == TIMEOUT - 1) begin
          pulse = owner;
          perr = !mem_ready;
          prdata = (mem_ready && !ot.we) ? mem_rdata : 32'h0;
          owner = 0;
        end else begin
          age++;
        end
      end else begin
        if ((ip && cur_pulse != 1) && (dp && cur_pulse != 2)) owner = m_last_d ? 1 : 2;
        else if (ip && cur_pulse != 1) owner = 1;
        else if (dp && cur_pulse != 2) owner = 2;
        if (owner != 0) begin
          ot = (owner == 1) ? it : dt;
          m_last_d = (owner == 2);
          age = 0;
          r = $urandom_range(99);
          if (r < 70) waitc = $urandom_range(3);
          else if (r < 80) waitc = $urandom_range(14, 4);
          else if (r < 88) waitc = TIMEOUT - 1;
          else waitc = 1000;
        end
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
